argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter CONF_MARGIN, default 16'd205, minimum best-minus-second-best probability (Q5.11, ~0.1) required to flag a confident result.
REQ-002 Clk  input  1  system clock; all state changes on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high reset; one clock and a synchronous active-high reset, no other clock domains.
REQ-004 Ready  input  1  level from the upstream network; high while the inference result is final.
REQ-005 Probability  input  16 x [9:0]  unsigned Q5.11 output-layer activations, index = digit; valid from the cycle after Ready is first sampled high.
REQ-006 Digit  output  4  index of the largest probability, 0-9.
REQ-007 MaxProb  output  16  value of the largest probability.
REQ-008 Margin  output  16  MaxProb minus second-largest probability.
REQ-009 Confident  output  1  high when Margin >= CONF_MARGIN.
REQ-010 Valid  output  1  one-cycle pulse when Digit/MaxProb/Margin/Confident update.
REQ-011 Busy  output  1  high while a capture or scan is in progress (states WAIT, SCAN).

Function
REQ-012 The block SHALL register Ready each cycle and detect a rising edge as Ready=1 with the registered copy = 0.
REQ-013 The state machine SHALL have states IDLE, WAIT, SCAN, DONE.
REQ-014 IDLE -> WAIT on a detected Ready rising edge; otherwise stay in IDLE.
REQ-015 WAIT SHALL last exactly one cycle, capture all ten Probability words into an internal buffer at its end, and go to SCAN with index 0.
REQ-016 SCAN SHALL examine one buffered word per cycle, index 0 through 9 (10 cycles), then go to DONE.
REQ-017 Index 0 SHALL load best=P[0], bestIdx=0, second=16'd0.
REQ-018 Index i>0: if P[i] > best then second=best, best=P[i], bestIdx=i; else if P[i] > second then second=P[i]; else no change.
REQ-019 Comparisons SHALL be unsigned and strict; on ties the lowest index wins and the tied value becomes second (Margin=0).
REQ-020 DONE SHALL last one cycle, load Digit=bestIdx, MaxProb=best, Margin=best-second (16-bit, never negative), Confident=(Margin >= CONF_MARGIN), pulse Valid, and return to IDLE.
REQ-021 Valid SHALL be high exactly 12 cycles after the cycle in which the Ready rising edge is sampled (1 WAIT + 10 SCAN + 1 DONE).
REQ-022 Digit, MaxProb, Margin, Confident SHALL hold their values between Valid pulses.
REQ-023 Ready edges arriving in WAIT, SCAN or DONE SHALL be ignored; Ready held high SHALL not retrigger; a new run requires Ready to fall and rise again.
REQ-024 Changes on Probability after the WAIT capture SHALL not affect the running scan.
REQ-025 Busy SHALL be high in WAIT and SCAN and low in IDLE and DONE.

Reset
REQ-026 Reset SHALL force state IDLE, Digit=0, MaxProb=0, Margin=0, Confident=0, Valid=0, Busy=0, registered Ready=0, buffer and scan registers cleared.
REQ-027 Reset asserted mid-WAIT or mid-SCAN SHALL abort the run with no Valid pulse and no output update.
REQ-028 If Ready is high on the first cycle after Reset deasserts, this SHALL count as a rising edge and start a run.

Verification
REQ-029 P={100,200,300,400,2000,500,600,700,800,900}, Ready rise at cycle T -> Valid at T+12, Digit=4, MaxProb=2000, Margin=1100, Confident=1, Busy high T+1..T+11.
REQ-030 P all 16'd1024 -> Digit=0, MaxProb=1024, Margin=0, Confident=0.
REQ-031 P[9]=2048, P[3]=1900, others 0 -> Digit=9, Margin=148, Confident=0 (148 < 205); P[3]=1843 -> Margin=205, Confident=1.
REQ-032 Ready held high 40 cycles -> exactly one Valid pulse; Ready low 1 cycle then high -> second run, second Valid pulse 12 cycles after the new edge.
REQ-033 Reset at scan index 5 -> no Valid, outputs read 0, Busy=0 next cycle; later Ready edge runs normally.
REQ-034 Probability changed to all 16'hFFFF two cycles into SCAN -> result reflects the values captured in WAIT.

Source files
------------

// File: rtl/argmax_classifier.sv
// Argmax classifier over ten Q5.11 activations.
// Captures on a Ready rising edge, scans one word per cycle, reports best and margin.
module argmax_classifier #(
    parameter logic [15:0] CONF_MARGIN = 16'd205
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Ready,
    input  logic [9:0][15:0] Probability,
    output logic [3:0]       Digit,
    output logic [15:0]      MaxProb,
    output logic [15:0]      Margin,
    output logic             Confident,
    output logic             Valid,
    output logic             Busy
);

    typedef enum logic [1:0] {IDLE, WAIT, SCAN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             ready_q;
    logic             rise;
    logic [9:0][15:0] buffer;
    logic [3:0]       idx;
    logic [15:0]      best;
    logic [15:0]      second;
    logic [3:0]       best_idx;
    logic [15:0]      word;
    logic [15:0]      best_next;
    logic [15:0]      second_next;
    logic [3:0]       best_idx_next;
    logic [15:0]      margin_next;
    logic             last;

    assign rise = Ready & ~ready_q;
    assign last = (idx == 4'd9);
    assign word = buffer[idx];

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        case (state)
            IDLE: if (rise) state_next = WAIT;
            WAIT: begin
                Busy       = 1'b1;
                state_next = SCAN;
            end
            SCAN: begin
                Busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strict compares keep the lowest index on ties; the tie value drops to second.
    always_comb begin
        best_next     = best;
        second_next   = second;
        best_idx_next = best_idx;
        if (idx == 4'd0) begin
            best_next     = word;
            second_next   = 16'd0;
            best_idx_next = 4'd0;
        end else if (word > best) begin
            second_next   = best;
            best_next     = word;
            best_idx_next = idx;
        end else if (word > second) begin
            second_next = word;
        end
        margin_next = best_next - second_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            buffer    <= '0;
            idx       <= 4'd0;
            best      <= 16'd0;
            second    <= 16'd0;
            best_idx  <= 4'd0;
            Digit     <= 4'd0;
            MaxProb   <= 16'd0;
            Margin    <= 16'd0;
            Confident <= 1'b0;
            Valid     <= 1'b0;
        end else begin
            ready_q <= Ready;
            state   <= state_next;
            Valid   <= 1'b0;
            if (state == WAIT) begin
                buffer <= Probability;
                idx    <= 4'd0;
            end
            if (state == SCAN) begin
                best     <= best_next;
                second   <= second_next;
                best_idx <= best_idx_next;
                idx      <= idx + 4'd1;
                if (last) begin
                    Digit     <= best_idx_next;
                    MaxProb   <= best_next;
                    Margin    <= margin_next;
                    Confident <= (margin_next >= CONF_MARGIN);
                    Valid     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed vectors with hand-computed results.
module tb_argmax_classifier;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Ready;
    logic [9:0][15:0] Probability;
    logic [3:0]       Digit;
    logic [15:0]      MaxProb;
    logic [15:0]      Margin;
    logic             Confident;
    logic             Valid;
    logic             Busy;

    argmax_classifier dut (
        .Clk(Clk), .Reset(Reset), .Ready(Ready),
        .Probability(Probability), .Digit(Digit),
        .MaxProb(MaxProb), .Margin(Margin),
        .Confident(Confident), .Valid(Valid), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  digit;
        logic [15:0] maxp;
        logic [15:0] margin;
        logic        conf;
        int          vcyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge Clk) begin
        if (Valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("valid_cycle", cyc, e.vcyc);
                check("digit", Digit, e.digit);
                check("maxprob", MaxProb, e.maxp);
                check("margin", Margin, e.margin);
                check("confident", Confident, e.conf);
            end
        end
    end

    function automatic logic [9:0][15:0] mk(
        input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        logic [9:0][15:0] p;
        p[0] = a0[15:0]; p[1] = a1[15:0]; p[2] = a2[15:0];
        p[3] = a3[15:0]; p[4] = a4[15:0]; p[5] = a5[15:0];
        p[6] = a6[15:0]; p[7] = a7[15:0]; p[8] = a8[15:0];
        p[9] = a9[15:0];
        return p;
    endfunction

    task automatic push(input int d, input int mp, input int mg, input bit c,
                        input int at);
        exp_t e;
        e.digit = d[3:0]; e.maxp = mp[15:0]; e.margin = mg[15:0];
        e.conf = c; e.vcyc = at;
        q.push_back(e);
    endtask

    // Raise Ready at a negedge; Valid is due 12 cycles later.
    task automatic start(input logic [9:0][15:0] p, input int d, input int mp,
                         input int mg, input bit c, input int hold);
        @(negedge Clk);
        Probability = p;
        Ready = 1'b1;
        push(d, mp, mg, c, cyc + 12);
        repeat (hold) @(negedge Clk);
        Ready = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge Clk);
        check("timeout_pending", q.size(), 0);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        int k;
        Reset = 1'b1;
        Ready = 1'b0;
        Probability = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_digit", Digit, 0);
        check("rst_maxprob", MaxProb, 0);
        check("rst_margin", Margin, 0);
        check("rst_conf", Confident, 0);
        check("rst_valid", Valid, 0);
        check("rst_busy", Busy, 0);

        // Basic run with Busy profile across the whole window.
        @(negedge Clk);
        k = cyc;
        Probability = mk(100, 200, 300, 400, 2000, 500, 600, 700, 800, 900);
        Ready = 1'b1;
        push(4, 2000, 1100, 1, k + 12);
        check("busy_t0", Busy, 0);
        for (int j = 1; j <= 12; j++) begin
            @(negedge Clk);
            if (j == 2) Ready = 1'b0;
            check($sformatf("busy_t%0d", j), Busy, (j <= 11) ? 1 : 0);
        end
        wait_done();

        start(mk(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024),
              0, 1024, 0, 0, 2);
        wait_done();
        start(mk(0, 0, 0, 1900, 0, 0, 0, 0, 0, 2048), 9, 2048, 148, 0, 2);
        wait_done();
        start(mk(0, 0, 0, 1843, 0, 0, 0, 0, 0, 2048), 9, 2048, 205, 1, 2);
        wait_done();

        // Ready held high: one pulse, then a 1-cycle low retriggers.
        start(mk(5, 6, 7, 8, 9, 10, 11, 300, 12, 13), 7, 300, 287, 1, 40);
        start(mk(700, 10, 20, 30, 40, 50, 60, 70, 80, 699), 0, 700, 1, 0, 2);
        wait_done();

        // Reset at scan index 5 aborts with no pulse.
        @(negedge Clk);
        k = cyc;
        Probability = mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 1000);
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
        while (cyc < k + 7) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_valid", Valid, 0);
        check("abort_digit", Digit, 0);
        check("abort_maxprob", MaxProb, 0);
        check("abort_margin", Margin, 0);
        repeat (16) @(negedge Clk);
        start(mk(10, 20, 30, 40, 50, 60, 70, 80, 90, 1000), 9, 1000, 910, 1, 2);
        wait_done();

        // Ready high through reset counts as an edge once reset drops.
        @(negedge Clk);
        Reset = 1'b1;
        Ready = 1'b1;
        Probability = mk(0, 0, 500, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b0;
        push(2, 500, 500, 1, cyc + 12);
        repeat (3) @(negedge Clk);
        Ready = 1'b0;
        wait_done();

        // Input changes two cycles into SCAN are not seen.
        @(negedge Clk);
        k = cyc;
        Probability = mk(300, 200, 100, 50, 40, 30, 20, 10, 5, 250);
        Ready = 1'b1;
        push(0, 300, 50, 0, k + 12);
        @(negedge Clk);
        Ready = 1'b0;
        while (cyc < k + 3) @(negedge Clk);
        Probability = '1;
        wait_done();

        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
